// File: rtl/preset_seq_pkg.sv
// Shared types for the preset/clock-enable release sequencer.
// Holds the FSM state encoding and the bank index width helper.
package preset_seq_pkg;

    typedef enum logic [1:0] {
        ST_ASSERT  = 2'd0,
        ST_RELEASE = 2'd1,
        ST_STAGGER = 2'd2,
        ST_RUN     = 2'd3
    } state_e;

    // Width of the bank index; a single bank still needs a 1-bit index.
    function automatic int idx_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/seq_cycle_counter.sv
// Up-counter with sync clear and a terminal-value compare; terminal flag is combinational
// from the registered count. No backpressure: inc/clr are obeyed every cycle.
module seq_cycle_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clr_i,
    input  logic             inc_i,
    input  logic [CNT_W-1:0] term_i,
    output logic             at_term_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign at_term_o = (cnt_q == term_i);

endmodule

// File: rtl/preset_release_sequencer.sv
// Holds all banks in preset, releases them in index order, enables each after ready + stagger.
// All outputs registered; a software req in RUN re-presets every bank with a one-cycle ack.
module preset_release_sequencer
    import preset_seq_pkg::*;
#(
    parameter int NUM_DOMAINS    = 4,
    parameter int HOLD_CYCLES    = 16,
    parameter int TIMEOUT_CYCLES = 64,
    parameter int STAGGER_CYCLES = 4,
    parameter int CNT_W          = 8
) (
    input  logic                   C,
    input  logic                   RST_N,
    input  logic                   req,
    input  logic [NUM_DOMAINS-1:0] rdy,
    output logic [NUM_DOMAINS-1:0] pre,
    output logic [NUM_DOMAINS-1:0] ce,
    output logic                   ack,
    output logic                   busy,
    output logic                   done,
    output logic [NUM_DOMAINS-1:0] err
);

    localparam int IDX_W = idx_w(NUM_DOMAINS);
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    if (NUM_DOMAINS < 1 || NUM_DOMAINS > 16) begin : g_bad_domains
        $error("NUM_DOMAINS must be in 1..16");
    end
    if (HOLD_CYCLES < 1 || TIMEOUT_CYCLES < 1 || STAGGER_CYCLES < 1) begin : g_bad_cycles
        $error("cycle parameters must be >= 1");
    end
    if (HOLD_CYCLES > CNT_MAX || TIMEOUT_CYCLES > CNT_MAX || STAGGER_CYCLES > CNT_MAX) begin : g_bad_cnt_w
        $error("CNT_W too narrow for the cycle parameters");
    end

    state_e                 state_q, state_d;
    logic [IDX_W-1:0]       k_q, k_d, k_nxt;
    logic [NUM_DOMAINS-1:0] pre_q, pre_d, ce_q, ce_d, err_q, err_d;
    logic                   ack_q, ack_d, busy_q, done_q;
    logic [NUM_DOMAINS-1:0] sel_k, sel_nxt;
    logic                   rdy_k, last_k;
    logic                   cnt_clr, cnt_inc, at_term;
    logic [CNT_W-1:0]       term;

    assign k_nxt  = k_q + IDX_W'(1);
    assign last_k = (k_q == IDX_W'(NUM_DOMAINS - 1));
    assign rdy_k  = |(rdy & sel_k);

    // One-hot selects for the current and next bank keep all indexing in range.
    always_comb begin
        sel_k   = '0;
        sel_nxt = '0;
        for (int j = 0; j < NUM_DOMAINS; j++) begin
            sel_k[j]   = (k_q == IDX_W'(j));
            sel_nxt[j] = (k_nxt == IDX_W'(j));
        end
    end

    always_comb begin
        case (state_q)
            ST_ASSERT:  term = CNT_W'(HOLD_CYCLES - 1);
            ST_RELEASE: term = CNT_W'(TIMEOUT_CYCLES - 1);
            ST_STAGGER: term = CNT_W'(STAGGER_CYCLES - 1);
            default:    term = '0;
        endcase
    end

    seq_cycle_counter #(
        .CNT_W(CNT_W)
    ) u_cnt (
        .clk_i    (C),
        .rst_ni   (RST_N),
        .clr_i    (cnt_clr),
        .inc_i    (cnt_inc),
        .term_i   (term),
        .at_term_o(at_term)
    );

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        pre_d   = pre_q;
        ce_d    = ce_q;
        err_d   = err_q;
        ack_d   = 1'b0;
        cnt_clr = 1'b0;
        cnt_inc = 1'b0;
        case (state_q)
            ST_ASSERT: begin
                pre_d   = '1;
                ce_d    = '0;
                cnt_inc = 1'b1;
                if (at_term) begin
                    state_d  = ST_RELEASE;
                    k_d      = '0;
                    pre_d[0] = 1'b0;
                    cnt_clr  = 1'b1;
                end
            end
            ST_RELEASE: begin
                // Ready takes priority over a timeout landing on the same edge.
                if (rdy_k) begin
                    state_d = ST_STAGGER;
                    cnt_clr = 1'b1;
                end else if (at_term) begin
                    err_d   = err_q | sel_k;
                    state_d = ST_STAGGER;
                    cnt_clr = 1'b1;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            ST_STAGGER: begin
                cnt_inc = 1'b1;
                if (at_term) begin
                    ce_d    = ce_q | sel_k;
                    cnt_clr = 1'b1;
                    if (last_k) begin
                        state_d = ST_RUN;
                    end else begin
                        k_d     = k_nxt;
                        pre_d   = pre_q & ~sel_nxt;
                        state_d = ST_RELEASE;
                    end
                end
            end
            default: begin
                cnt_clr = 1'b1;
                pre_d   = '0;
                ce_d    = '1;
                if (req) begin
                    state_d = ST_ASSERT;
                    ack_d   = 1'b1;
                    pre_d   = '1;
                    ce_d    = '0;
                    err_d   = '0;
                end
            end
        endcase
    end

    always_ff @(posedge C or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= ST_ASSERT;
            k_q     <= '0;
            pre_q   <= '1;
            ce_q    <= '0;
            err_q   <= '0;
            ack_q   <= 1'b0;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            pre_q   <= pre_d;
            ce_q    <= ce_d;
            err_q   <= err_d;
            ack_q   <= ack_d;
            busy_q  <= (state_d != ST_RUN);
            done_q  <= (state_d == ST_RUN);
        end
    end

    assign pre  = pre_q;
    assign ce   = ce_q;
    assign err  = err_q;
    assign ack  = ack_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule
